// File: rtl/cpu_pkg.sv
// cpu_pkg: jump codes, reset/bubble constants and fetch FSM encoding shared by fetch and decode
package cpu_pkg;
  localparam logic [3:0] NPC = 4'd0;
  localparam logic [3:0] OFFPC = 4'd1;
  localparam logic [3:0] NEQ = 4'd2;
  localparam logic [3:0] EQ = 4'd3;
  localparam logic [3:0] SLT = 4'd4;
  localparam logic [3:0] ULT = 4'd5;
  localparam logic [3:0] JALR = 4'd6;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} fetch_state_t;
endpackage

// File: rtl/branch_resolve.sv
// branch_resolve: combinational next-pc from jump code and operands (pc, imm, alu_result, rs1/rs2, jump_ctrl -> next_pc)
module branch_resolve import cpu_pkg::*; (
  input logic [31:0] pc,
  input logic [31:0] imm,
  input logic [31:0] alu_result,
  input logic [31:0] rs1_data,
  input logic [31:0] rs2_data,
  input logic [3:0] jump_ctrl,
  output logic [31:0] next_pc
);
  logic taken;
  logic [31:0] target;
  always_comb begin
    taken = jump_ctrl == OFFPC ||
      (jump_ctrl == EQ && rs1_data == rs2_data) ||
      (jump_ctrl == NEQ && rs1_data != rs2_data) ||
      (jump_ctrl == SLT && $signed(rs1_data) < $signed(rs2_data)) ||
      (jump_ctrl == ULT && rs1_data < rs2_data);
    target = jump_ctrl == JALR ? alu_result : taken ? pc + imm : pc + 32'd4;
    next_pc = target & ~32'd3;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: pc register, single-outstanding imem req/ack fetch, retire-driven next-pc update and instret counter
module fetch_unit import cpu_pkg::*; #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input logic clk,
  input logic rst,
  output logic imem_req,
  output logic [31:0] imem_addr,
  input logic imem_ack,
  input logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input logic retire,
  input logic [3:0] jump_ctrl,
  input logic [31:0] imm,
  input logic [31:0] alu_result,
  input logic [31:0] rs1_data,
  input logic [31:0] rs2_data,
  output logic [31:0] instret
);
  fetch_state_t state, state_next;
  logic capture, retire_ok;
  logic [31:0] next_pc;
  branch_resolve u_br (
    .pc(pc),
    .imm(imm),
    .alu_result(alu_result),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .jump_ctrl(jump_ctrl),
    .next_pc(next_pc)
  );
  assign imem_req = state == FETCH || state == WAIT;
  assign imem_addr = pc;
  assign inst_valid = state == HOLD;
  assign pc_plus4 = pc + 32'd4;
  assign capture = imem_req && imem_ack;
  assign retire_ok = state == HOLD && retire;
  always_comb begin
    state_next = state == IDLE ? FETCH :
                 imem_req ? (imem_ack ? HOLD : WAIT) :
                 retire_ok ? FETCH : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      inst <= NOP_INST;
      instret <= 32'd0;
    end else begin
      state <= state_next;
      if (capture) inst <= imem_rdata;
      else if (retire_ok) begin
        inst <= NOP_INST;
        pc <= next_pc;
        instret <= instret + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic clk = 0, rst = 1, imem_ack = 0, retire = 0;
  logic [31:0] imem_rdata = 0, imm = 0, alu_result = 0, rs1_data = 0, rs2_data = 0;
  logic [3:0] jump_ctrl = 0;
  logic imem_req, inst_valid;
  logic [31:0] imem_addr, inst, pc, pc_plus4, instret;
  int tests = 0, fails = 0;
  logic [31:0] exp_instret = 0;
  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
    .pc(pc), .pc_plus4(pc_plus4), .retire(retire), .jump_ctrl(jump_ctrl), .imm(imm),
    .alu_result(alu_result), .rs1_data(rs1_data), .rs2_data(rs2_data), .instret(instret)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [31:0] data);
    imem_ack = 1;
    imem_rdata = data;
    step();
    imem_ack = 0;
  endtask
  task automatic do_retire(input logic [3:0] jc, input logic [31:0] im, input logic [31:0] alu,
                           input logic [31:0] a, input logic [31:0] b);
    jump_ctrl = jc; imm = im; alu_result = alu; rs1_data = a; rs2_data = b;
    retire = 1;
    step();
    retire = 0;
    exp_instret = exp_instret + 1;
  endtask
  task automatic set_pc(input logic [31:0] target);
    fetch(32'h0000_0013);
    do_retire(4'd6, 32'd0, target, 32'd0, 32'd0);
  endtask
  task automatic test_reset();
    step(); step();
    tests++; if (pc !== 32'h3000) begin fails++; $display("FAIL reset_pc got %h want %h", pc, 32'h3000); end
    tests++; if (inst !== 32'h0) begin fails++; $display("FAIL reset_inst got %h want 0", inst); end
    tests++; if ({imem_req, inst_valid} !== 2'b00) begin fails++; $display("FAIL reset_req_valid got %b want 00", {imem_req, inst_valid}); end
    tests++; if (instret !== 32'd0) begin fails++; $display("FAIL reset_instret got %0d want 0", instret); end
    rst = 0;
    step();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin fails++; $display("FAIL first_fetch got req=%b addr=%h want 1 3000", imem_req, imem_addr); end
  endtask
  task automatic test_zero_wait();
    fetch(32'h0010_0093);
    tests++; if (inst_valid !== 1'b1 || inst !== 32'h0010_0093) begin fails++; $display("FAIL zw_capture got v=%b inst=%h want 1 00100093", inst_valid, inst); end
    tests++; if (imem_req !== 1'b0 || pc !== 32'h3000 || pc_plus4 !== 32'h3004) begin fails++; $display("FAIL zw_hold got req=%b pc=%h p4=%h", imem_req, pc, pc_plus4); end
    do_retire(4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    tests++; if (imem_addr !== 32'h3004 || instret !== 32'd1) begin fails++; $display("FAIL zw_retire got addr=%h instret=%0d want 3004 1", imem_addr, instret); end
    tests++; if (inst_valid !== 1'b0 || inst !== 32'h0) begin fails++; $display("FAIL zw_bubble got v=%b inst=%h want 0 0", inst_valid, inst); end
  endtask
  task automatic test_wait();
    for (int i = 0; i < 3; i++) begin
      tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004 || inst_valid !== 1'b0) begin fails++; $display("FAIL wait_cycle%0d got req=%b addr=%h v=%b", i, imem_req, imem_addr, inst_valid); end
      step();
    end
    imem_ack = 1; imem_rdata = 32'h00A0_0113;
    #1;
    tests++; if (inst_valid !== 1'b0 || imem_req !== 1'b1) begin fails++; $display("FAIL wait_ack_cycle got v=%b req=%b want 0 1", inst_valid, imem_req); end
    step();
    imem_ack = 0;
    tests++; if (inst_valid !== 1'b1 || inst !== 32'h00A0_0113) begin fails++; $display("FAIL wait_capture got v=%b inst=%h", inst_valid, inst); end
    do_retire(4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    tests++; if (pc !== 32'h3008 || instret !== exp_instret) begin fails++; $display("FAIL wait_retire got pc=%h instret=%0d want 3008 %0d", pc, instret, exp_instret); end
  endtask
  task automatic test_retire_ignored();
    jump_ctrl = 4'd1; imm = 32'h100; retire = 1;
    step(); step();
    retire = 0;
    tests++; if (pc !== 32'h3008 || instret !== exp_instret || imem_req !== 1'b1) begin fails++; $display("FAIL retire_ignored got pc=%h instret=%0d req=%b", pc, instret, imem_req); end
  endtask
  task automatic test_branch();
    logic [3:0] jc [10] = '{4'd3, 4'd3, 4'd2, 4'd2, 4'd4, 4'd5, 4'd1, 4'd0, 4'd9, 4'd6};
    logic [31:0] a [10] = '{5, 5, 5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0};
    logic [31:0] b [10] = '{5, 6, 6, 5, 1, 1, 0, 0, 0, 0};
    logic [31:0] exp [10] = '{32'h3000, 32'h3014, 32'h3000, 32'h3014, 32'h3000, 32'h3014, 32'h3000, 32'h3014, 32'h3014, 32'h3100};
    for (int i = 0; i < 10; i++) begin
      set_pc(32'h3010);
      fetch(32'h0000_0063);
      do_retire(jc[i], 32'hFFFF_FFF0, 32'h0000_3103, a[i], b[i]);
      tests++; if (imem_addr !== exp[i]) begin fails++; $display("FAIL branch%0d jc=%0d got %h want %h", i, jc[i], imem_addr, exp[i]); end
    end
    tests++; if (instret !== exp_instret) begin fails++; $display("FAIL branch_instret got %0d want %0d", instret, exp_instret); end
  endtask
  task automatic test_wrap();
    set_pc(32'hFFFF_FFFC);
    tests++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin fails++; $display("FAIL wrap_p4 got pc=%h p4=%h want fffffffc 0", pc, pc_plus4); end
    fetch(32'h0000_0013);
    do_retire(4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL wrap_npc got %h want 0", pc); end
  endtask
  task automatic test_reset_in_wait();
    step();
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; rst = 1;
    #1;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req_drop got %b want 0", imem_req); end
    step();
    imem_ack = 0;
    tests++; if (pc !== 32'h3000 || inst !== 32'h0 || instret !== 32'd0 || inst_valid !== 1'b0) begin fails++; $display("FAIL rst_wait_state got pc=%h inst=%h instret=%0d v=%b", pc, inst, instret, inst_valid); end
    rst = 0;
    step();
    exp_instret = 0;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || inst !== 32'h0 || inst_valid !== 1'b0) begin fails++; $display("FAIL rst_release got req=%b addr=%h inst=%h v=%b", imem_req, imem_addr, inst, inst_valid); end
    fetch(32'h0000_0073);
    tests++; if (inst !== 32'h0000_0073) begin fails++; $display("FAIL rst_refetch got %h want 00000073", inst); end
  endtask
  initial begin
    test_reset();
    test_zero_wait();
    test_wait();
    test_retire_ignored();
    fetch(32'h0000_0013);
    do_retire(4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    test_branch();
    test_wrap();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
